// File: rtl/sevseg_pkg.sv
// sevseg_pkg
// Shared types and helpers for the seven-segment scan controller.
//   seg7_t     : active-low segment vector ordered {g,f,e,d,c,b,a}
//   SEG_BLANK  : all segments dark
//   hex_to_seg : hex nibble to active-low glyph
package sevseg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  // Common-anode glyphs, so a 0 bit lights the segment.
  function automatic seg7_t hex_to_seg(input logic [3:0] nib);
    seg7_t glyph;
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/sevseg_lz_mask.sv
// sevseg_lz_mask
// Combinational leading-zero blanking mask.
//   nibbles  : active hex nibbles, nibble i is digit i (digit 0 rightmost)
//   blank_lz : blanking enable
//   mask     : bit i set when digit i should be dark; bit 0 is never set
module sevseg_lz_mask
  import sevseg_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] nibbles,
  input  logic                blank_lz,
  output logic [DIGITS-1:0]   mask
);

  logic higher_zero;

  // Walk from the leftmost digit toward digit 1, carrying whether every
  // nibble seen so far is zero; the first non-zero nibble stops blanking.
  always_comb begin
    mask        = '0;
    higher_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      higher_zero = higher_zero & (nibbles[4*i +: 4] == 4'h0);
      mask[i]     = blank_lz & higher_zero;
    end
  end

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// sevseg_scan_ctrl
// Time-multiplexed driver for DIGITS common-anode seven-segment digits with
// per-digit decimal points, blinking, leading-zero blanking and
// frame-synchronous double-buffered loading.
//   clk, rst        : clock, asynchronous active-high reset
//   load            : strobe capturing digits_in/dp_in/blink_in into shadow
//   digits_in       : hex nibbles, nibble i = digit i (digit 0 rightmost)
//   dp_in, blink_in : per-digit decimal point / blink enables
//   blank_lz        : live leading-zero blanking enable
//   enable          : live global anode enable
//   seg, dp, an     : registered active-low segment, point and anode drives
//   frame_start     : pulse on the first output cycle of digit 0
//   pending         : shadow data waits for the next frame boundary
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DIV_BITS   = 16,
  parameter int BLINK_BITS = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] digits_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blink_in,
  input  logic                blank_lz,
  input  logic                enable,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an,
  output logic                frame_start,
  output logic                pending
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [DIV_BITS-1:0]   div_cnt;
  logic [IDX_W-1:0]      idx;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  div_wrap;
  logic                  commit;
  logic                  blink_phase;

  logic [4*DIGITS-1:0]   shadow_digits;
  logic [DIGITS-1:0]     shadow_dp;
  logic [DIGITS-1:0]     shadow_blink;
  logic [4*DIGITS-1:0]   active_digits;
  logic [DIGITS-1:0]     active_dp;
  logic [DIGITS-1:0]     active_blink;

  logic [DIGITS-1:0]     blank_mask;
  logic [3:0]            sel_nib;
  logic                  sel_dp;
  logic [DIGITS-1:0]     an_nxt;

  assign div_wrap    = &div_cnt;
  assign commit      = div_wrap && (idx == LAST_IDX);
  assign blink_phase = blink_cnt[BLINK_BITS-1];

  // Free-running divider and blink counters; the scan index steps on every
  // divider wrap and returns to digit 0 after the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      idx       <= '0;
      blink_cnt <= '0;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
      if (div_wrap) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  // Double buffer: active data only changes together with the index moving
  // back to digit 0, so a frame never mixes old and new data. A load landing
  // on that same cycle goes straight through and leaves nothing pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_blink  <= '0;
      active_digits <= '0;
      active_dp     <= '0;
      active_blink  <= '0;
      pending       <= 1'b0;
    end else if (load) begin
      shadow_digits <= digits_in;
      shadow_dp     <= dp_in;
      shadow_blink  <= blink_in;
      if (commit) begin
        active_digits <= digits_in;
        active_dp     <= dp_in;
        active_blink  <= blink_in;
        pending       <= 1'b0;
      end else begin
        pending       <= 1'b1;
      end
    end else if (commit && pending) begin
      active_digits <= shadow_digits;
      active_dp     <= shadow_dp;
      active_blink  <= shadow_blink;
      pending       <= 1'b0;
    end
  end

  sevseg_lz_mask #(
    .DIGITS (DIGITS)
  ) u_lz_mask (
    .nibbles  (active_digits),
    .blank_lz (blank_lz),
    .mask     (blank_mask)
  );

  // Select the current digit's data and decide whether its anode may light;
  // only the selected bit can ever go low, so anodes are one-cold at most.
  always_comb begin
    sel_nib = 4'h0;
    sel_dp  = 1'b0;
    an_nxt  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_nib   = active_digits[4*i +: 4];
        sel_dp    = active_dp[i];
        an_nxt[i] = ~(enable & ~blank_mask[i] & ~(active_blink[i] & blink_phase));
      end
    end
  end

  // Registered pin drivers, one clock behind the index. frame_start marks
  // the first output cycle of digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      seg         <= hex_to_seg(sel_nib);
      dp          <= ~sel_dp;
      an          <= an_nxt;
      frame_start <= (idx == '0) && (div_cnt == '0);
    end
  end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
module tb_sevseg_scan_ctrl;

  localparam int DIGITS     = 4;
  localparam int DIV_BITS   = 2;
  localparam int BLINK_BITS = 6;
  localparam int SLOT       = 1 << DIV_BITS;
  localparam int FRAME      = DIGITS * SLOT;
  localparam int BLINK_PER  = 1 << BLINK_BITS;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blink_in;
  logic        blank_lz;
  logic        enable;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;
  logic        pending;

  sevseg_scan_ctrl #(
    .DIGITS     (DIGITS),
    .DIV_BITS   (DIV_BITS),
    .BLINK_BITS (BLINK_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blink_in    (blink_in),
    .blank_lz    (blank_lz),
    .enable      (enable),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: clocks since reset, plus visible/shadow data.
  int          cnt;
  logic [15:0] m_act, m_sh;
  logic [3:0]  m_act_dp, m_act_bl, m_sh_dp, m_sh_bl;
  logic        m_pend;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_fs;
  logic        exp_pend;

  int checks;
  int fails;

  task automatic modelReset();
    cnt      = 0;
    m_act    = '0;
    m_sh     = '0;
    m_act_dp = '0;
    m_act_bl = '0;
    m_sh_dp  = '0;
    m_sh_bl  = '0;
    m_pend   = 1'b0;
    exp_seg  = 7'h7F;
    exp_dp   = 1'b1;
    exp_an   = 4'hF;
    exp_fs   = 1'b0;
    exp_pend = 1'b0;
  endtask

  // Outputs after an edge describe the state just before it: the digit
  // slot is the clock count divided into slots, blink phase is the upper
  // half of the blink period. Frame boundary = last clock of a frame.
  task automatic modelEdge();
    int  pre;
    int  d;
    bit  phase;
    bit  blanked;
    bit  boundary;
    pre      = cnt;
    d        = (pre / SLOT) % DIGITS;
    phase    = (pre % BLINK_PER) >= (BLINK_PER / 2);
    blanked  = blank_lz && (d >= 1) && ((m_act >> (4 * d)) == 16'h0);
    exp_seg  = glyph[m_act[4*d +: 4]];
    exp_dp   = ~m_act_dp[d];
    exp_an   = 4'hF;
    if (enable && !blanked && !(m_act_bl[d] && phase)) exp_an[d] = 1'b0;
    exp_fs   = (pre % FRAME) == 0;
    boundary = (pre % FRAME) == (FRAME - 1);
    if (load) begin
      m_sh    = digits_in;
      m_sh_dp = dp_in;
      m_sh_bl = blink_in;
      if (boundary) begin
        m_act    = digits_in;
        m_act_dp = dp_in;
        m_act_bl = blink_in;
        m_pend   = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end else if (boundary && m_pend) begin
      m_act    = m_sh;
      m_act_dp = m_sh_dp;
      m_act_bl = m_sh_bl;
      m_pend   = 1'b0;
    end
    exp_pend = m_pend;
    cnt++;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (an === exp_an) else begin
      fails++;
      $error("[TB] FAIL %s an observed=%b expected=%b t=%0t", tag, an, exp_an, $time);
    end
    checks++;
    assert (seg === exp_seg) else begin
      fails++;
      $error("[TB] FAIL %s seg observed=%h expected=%h t=%0t", tag, seg, exp_seg, $time);
    end
    checks++;
    assert (dp === exp_dp) else begin
      fails++;
      $error("[TB] FAIL %s dp observed=%b expected=%b t=%0t", tag, dp, exp_dp, $time);
    end
    checks++;
    assert (frame_start === exp_fs) else begin
      fails++;
      $error("[TB] FAIL %s frame_start observed=%b expected=%b t=%0t", tag, frame_start, exp_fs, $time);
    end
    checks++;
    assert (pending === exp_pend) else begin
      fails++;
      $error("[TB] FAIL %s pending observed=%b expected=%b t=%0t", tag, pending, exp_pend, $time);
    end
    checks++;
    assert ($countones(~an) <= 1) else begin
      fails++;
      $error("[TB] FAIL %s one_cold_an observed=%b expected=at_most_one_low t=%0t", tag, an, $time);
    end
  endtask

  // Drive inputs away from the edge, let one clock pass, then compare.
  task automatic applyStimulus(input logic l, input logic [15:0] d, input logic [3:0] p,
                               input logic [3:0] b, input logic blz, input logic en,
                               input string tag);
    load      = l;
    digits_in = d;
    dp_in     = p;
    blink_in  = b;
    blank_lz  = blz;
    enable    = en;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, digits_in, dp_in, blink_in, blank_lz, enable, tag);
  endtask

  task automatic checkReset(input string tag);
    exp_seg  = 7'h7F;
    exp_dp   = 1'b1;
    exp_an   = 4'hF;
    exp_fs   = 1'b0;
    exp_pend = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    rst       = 1'b1;
    load      = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    blink_in  = '0;
    blank_lz  = 1'b0;
    enable    = 1'b1;
    modelReset();
    #3;
    checkReset("reset_async");
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset_held");
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");

    // Scan with zero data: 1110, 1101, 1011, 0111, each for four clocks.
    idle(FRAME, "scan");

    // Mid-frame load, committed only at the frame boundary.
    idle(5, "pre_load");
    applyStimulus(1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0, 1'b1, "load_12AF");
    idle(2 * FRAME, "commit_12AF");

    // Load landing exactly on the commit cycle.
    while ((cnt % FRAME) != FRAME - 1) idle(1, "align");
    applyStimulus(1'b1, 16'h3C7D, 4'h0, 4'h0, 1'b0, 1'b1, "load_on_commit");
    idle(FRAME, "after_commit_load");

    // Back-to-back loads: the last one wins.
    idle(3, "gap");
    applyStimulus(1'b1, 16'h1111, 4'h0, 4'h0, 1'b0, 1'b1, "b2b_first");
    applyStimulus(1'b1, 16'h9E64, 4'h0, 4'h0, 1'b0, 1'b1, "b2b_last");
    idle(2 * FRAME, "b2b_show");

    // Leading-zero blanking.
    applyStimulus(1'b1, 16'h0050, 4'h0, 4'h0, 1'b1, 1'b1, "lz_0050");
    idle(2 * FRAME, "lz_0050_show");
    applyStimulus(1'b1, 16'h0000, 4'h0, 4'h0, 1'b1, 1'b1, "lz_0000");
    idle(2 * FRAME, "lz_0000_show");
    applyStimulus(1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, "lz_off");
    idle(FRAME, "lz_off_show");

    // Blink on digit 2 and decimal point on digit 0 across full blink periods.
    applyStimulus(1'b1, 16'h8421, 4'b0001, 4'b0100, 1'b0, 1'b1, "blink_dp");
    idle(2 * BLINK_PER, "blink_dp_show");

    // Global enable off, then back on.
    applyStimulus(1'b0, digits_in, dp_in, blink_in, 1'b0, 1'b0, "disable");
    idle(FRAME, "disabled");
    applyStimulus(1'b0, digits_in, dp_in, blink_in, 1'b0, 1'b1, "reenable");
    idle(FRAME, "reenabled");

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      applyStimulus(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 4'($urandom),
                    ($urandom_range(0, 15) == 0) ? ~blank_lz : blank_lz,
                    ($urandom_range(0, 9) != 0), "random");
    end

    // Reset mid-frame with a load waiting: outputs drop immediately and the
    // pending data is lost.
    while ((cnt % FRAME) == 0 || (cnt % FRAME) >= FRAME - 3) idle(1, "align_rst");
    applyStimulus(1'b1, 16'hBEEF, 4'hF, 4'h0, 1'b0, 1'b1, "load_before_rst");
    idle(1, "pending_before_rst");
    #3;
    rst = 1'b1;
    #1;
    modelReset();
    checkReset("rst_midframe_async");
    @(negedge clk);
    @(posedge clk);
    #1;
    checkReset("rst_midframe_held");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, "post_rst");
    idle(2 * FRAME, "post_rst_show");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
